// File: rtl/addsub19_arbiter.sv
// Round-robin arbiter sharing one 19-bit carry-lookahead add/sub unit among four requesters.
// Results land in a one-deep output register with backpressure, tagged with the requester id.

module cla19 #(
   parameter int WIDTH = 19
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum
);
   localparam int GRP = 4;
   localparam int NG  = (WIDTH + GRP - 1) / GRP;

   logic [WIDTH-1:0] p, g;
   logic [NG-1:0]    gg, pg;
   logic [NG:0]      gc;

   assign p = a ^ b;
   assign g = a & b;

   // Group generate/propagate, then a lookahead carry across groups.
   always_comb begin
      gg = '0;
      pg = '0;
      gc = '0;
      gc[0] = cin;
      for (int k = 0; k < NG; k++) begin
         pg[k] = 1'b1;
         for (int j = 0; j < GRP; j++) begin
            if (k * GRP + j < WIDTH) begin
               gg[k] = g[k*GRP+j] | (p[k*GRP+j] & gg[k]);
               pg[k] = pg[k] & p[k*GRP+j];
            end
         end
         gc[k+1] = gg[k] | (pg[k] & gc[k]);
      end
   end

   always_comb begin : sum_gen
      logic cy;
      sum = '0;
      cy  = 1'b0;
      for (int k = 0; k < NG; k++) begin
         cy = gc[k];
         for (int j = 0; j < GRP; j++) begin
            if (k * GRP + j < WIDTH) begin
               sum[k*GRP+j] = p[k*GRP+j] ^ cy;
               cy = g[k*GRP+j] | (p[k*GRP+j] & cy);
            end
         end
      end
   end
endmodule

module addsub19_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req_valid,
   input  logic [75:0] req_a,
   input  logic [75:0] req_b,
   input  logic [3:0]  req_sub,
   output logic [3:0]  req_ready,
   output logic        rsp_valid,
   output logic [18:0] rsp_data,
   output logic [1:0]  rsp_id,
   input  logic        rsp_ready,
   output logic [15:0] op_count
);
   localparam int WIDTH = 19;
   localparam int NREQ  = 4;

   logic [1:0]       ptr;
   logic [NREQ-1:0]  gnt;
   logic [1:0]       gnt_id;
   logic             found;
   logic [1:0]       idx;
   logic             can_accept;
   logic             req_fire;
   logic             rsp_fire;
   logic [WIDTH-1:0] a_sel, b_sel, b_eff, sum;
   logic             sub_sel;

   // First valid requester starting at ptr and wrapping.
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = ptr + 2'(k);
         if (!found && req_valid[idx]) begin
            found       = 1'b1;
            gnt[idx]    = 1'b1;
            gnt_id      = idx;
         end
      end
   end

   assign can_accept = !rsp_valid || rsp_ready;
   assign req_ready  = gnt & {NREQ{can_accept & ~rst}};
   assign req_fire   = |(req_valid & req_ready);
   assign rsp_fire   = rsp_valid & rsp_ready;

   assign a_sel   = req_a[gnt_id*WIDTH +: WIDTH];
   assign b_sel   = req_b[gnt_id*WIDTH +: WIDTH];
   assign sub_sel = req_sub[gnt_id];
   assign b_eff   = b_sel ^ {WIDTH{sub_sel}};

   cla19 #(.WIDTH(WIDTH)) u_cla19 (
      .a   (a_sel),
      .b   (b_eff),
      .cin (sub_sel),
      .sum (sum)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= '0;
         ptr       <= '0;
         op_count  <= '0;
      end else begin
         // A new accept overrides the drain so back-to-back ops keep rsp_valid high.
         if (req_fire) begin
            rsp_valid <= 1'b1;
            rsp_data  <= sum;
            rsp_id    <= gnt_id;
            ptr       <= gnt_id + 2'd1;
         end else if (rsp_fire) begin
            rsp_valid <= 1'b0;
         end
         if (rsp_fire) begin
            op_count <= op_count + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_addsub19_arbiter.sv
// Directed bench for addsub19_arbiter: reset, arithmetic wrap, round-robin order,
// backpressure, overlapping handshakes, mid-stream reset and op_count wrap.

module tb_addsub19_arbiter;
   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [75:0] req_a;
   logic [75:0] req_b;
   logic [3:0]  req_sub;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [18:0] rsp_data;
   logic [1:0]  rsp_id;
   logic        rsp_ready;
   logic [15:0] op_count;

   int checks = 0;
   int errors = 0;
   logic [18:0] rr_exp [4];

   addsub19_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sub   (req_sub),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_ready (rsp_ready),
      .op_count  (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [18:0] a, input logic [18:0] b, input logic s);
      req_a[i*19 +: 19] = a;
      req_b[i*19 +: 19] = b;
      req_sub[i]        = s;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One request from requester id with rsp_ready high; checks the registered result.
   task automatic single_op(input int id, input logic [18:0] a, input logic [18:0] b,
                            input logic s, input logic [18:0] exp);
      set_req(id, a, b, s);
      req_valid = 4'b0001 << id;
      rsp_ready = 1'b1;
      step();
      req_valid = 4'b0000;
      chk("op_valid", 32'(rsp_valid), 32'd1);
      chk("op_data", 32'(rsp_data), 32'(exp));
      chk("op_id", 32'(rsp_id), 32'(id));
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 4'hF;
      req_a     = '0;
      req_b     = '0;
      req_sub   = '0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_data", 32'(rsp_data), 32'd0);
      chk("rst_id", 32'(rsp_id), 32'd0);
      chk("rst_count", 32'(op_count), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);

      // single request from requester 2: 5 - 3
      rst       = 1'b0;
      req_valid = 4'b0100;
      set_req(2, 19'h00005, 19'h00003, 1'b1);
      #1 chk("sr_ready", 32'(req_ready), 32'b0100);
      step();
      req_valid = 4'b0000;
      chk("sr_valid", 32'(rsp_valid), 32'd1);
      chk("sr_data", 32'(rsp_data), 32'h00002);
      chk("sr_id", 32'(rsp_id), 32'd2);
      rsp_ready = 1'b1;
      step();
      chk("sr_drain", 32'(rsp_valid), 32'd0);
      chk("sr_count", 32'(op_count), 32'd1);

      // wrap-around arithmetic; last op from requester 3 leaves ptr at 0
      single_op(0, 19'h00000, 19'h00001, 1'b1, 19'h7FFFF);
      single_op(1, 19'h7FFFF, 19'h00001, 1'b0, 19'h00000);
      single_op(3, 19'h40000, 19'h40000, 1'b0, 19'h00000);
      step();
      chk("wr_count", 32'(op_count), 32'd4);
      chk("wr_drain", 32'(rsp_valid), 32'd0);

      // round robin with all four valid
      set_req(0, 19'h00100, 19'd1, 1'b0);
      set_req(1, 19'h00200, 19'd2, 1'b1);
      set_req(2, 19'h00300, 19'd3, 1'b0);
      set_req(3, 19'h00400, 19'd4, 1'b1);
      rr_exp[0] = 19'h00101;
      rr_exp[1] = 19'h001FE;
      rr_exp[2] = 19'h00303;
      rr_exp[3] = 19'h003FC;
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("rr_valid", 32'(rsp_valid), 32'd1);
         chk("rr_id", 32'(rsp_id), 32'(k % 4));
         chk("rr_data", 32'(rsp_data), 32'(rr_exp[k % 4]));
         chk("rr_count", 32'(op_count), 32'(4 + k));
      end
      req_valid = 4'b0000;
      step();
      chk("rr_drain", 32'(rsp_valid), 32'd0);
      chk("rr_count_end", 32'(op_count), 32'd10);

      // backpressure after a result from requester 1 (ptr is 2 here)
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      step();
      req_valid = 4'b0101;
      #1 chk("bp_ready0", 32'(req_ready), 32'd0);
      for (int k = 0; k < 3; k++) begin
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_id", 32'(rsp_id), 32'd1);
         chk("bp_data", 32'(rsp_data), 32'h001FE);
         chk("bp_ready", 32'(req_ready), 32'd0);
         step();
      end
      chk("bp_hold_id", 32'(rsp_id), 32'd1);
      chk("bp_count", 32'(op_count), 32'd10);
      rsp_ready = 1'b1;
      #1 chk("bp_release_ready", 32'(req_ready), 32'b0100);
      step();
      req_valid = 4'b0001;
      chk("sim_valid", 32'(rsp_valid), 32'd1);
      chk("sim_id", 32'(rsp_id), 32'd2);
      chk("sim_data", 32'(rsp_data), 32'h00303);
      chk("sim_count", 32'(op_count), 32'd11);
      step();
      req_valid = 4'b0000;
      chk("sim2_valid", 32'(rsp_valid), 32'd1);
      chk("sim2_id", 32'(rsp_id), 32'd0);
      chk("sim2_data", 32'(rsp_data), 32'h00101);
      chk("sim2_count", 32'(op_count), 32'd12);
      step();
      chk("sim_drain", 32'(rsp_valid), 32'd0);
      chk("sim_count_end", 32'(op_count), 32'd13);

      // reset mid-stream with a result pending (ptr left at 3 before reset)
      req_valid = 4'b0100;
      rsp_ready = 1'b0;
      step();
      chk("mr_pend_valid", 32'(rsp_valid), 32'd1);
      chk("mr_pend_id", 32'(rsp_id), 32'd2);
      rst       = 1'b1;
      req_valid = 4'b1010;
      step();
      chk("mr_valid", 32'(rsp_valid), 32'd0);
      chk("mr_count", 32'(op_count), 32'd0);
      chk("mr_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      #1 chk("mr_first_grant", 32'(req_ready), 32'b0010);
      step();
      req_valid = 4'b0000;
      chk("mr_id", 32'(rsp_id), 32'd1);
      chk("mr_data", 32'(rsp_data), 32'h001FE);
      rsp_ready = 1'b1;
      step();
      chk("mr_drain", 32'(rsp_valid), 32'd0);
      chk("mr_count_after", 32'(op_count), 32'd1);

      // op_count wrap: 65534 more handshakes reach 0xFFFF, one more wraps to 0
      req_valid = 4'b0001;
      repeat (65534) @(posedge clk);
      @(negedge clk);
      req_valid = 4'b0000;
      step();
      chk("cnt_ffff", 32'(op_count), 32'h0000FFFF);
      single_op(0, 19'h00001, 19'h00002, 1'b0, 19'h00003);
      step();
      chk("cnt_wrap", 32'(op_count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/addsub19_arbiter.md
# addsub19_arbiter

Shares the team's single 19-bit carry-lookahead add/sub unit (cla19) among four requesters (the trapezoid edge walkers and span interpolators) using round-robin arbitration and a valid/ready handshake. It registers one result per cycle into a one-deep output stage with backpressure, tags each result with the requester ID, and keeps a running count of completed operations. It sits between the edge/span stepping logic and the shared adder.

## Interface
- WIDTH, 19, operand and result width; fixed by the adder, not to be overridden
- NREQ, 4, number of requesters; fixed at 4 with a 2-bit ID
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  4  per-requester operation request
- req_a  input  76  operand A; requester i drives bits [19i+18:19i]
- req_b  input  76  operand B, same packing as req_a
- req_sub  input  4  per-requester opcode: 1 = A−B, 0 = A+B
- req_ready  output  4  one-hot grant; request i is accepted when req_valid[i] and req_ready[i] are both high at a rising edge
- rsp_valid  output  1  result register holds valid data
- rsp_data  output  19  result, modulo 2^19
- rsp_id  output  2  index of the requester that produced rsp_data
- rsp_ready  input  1  consumer accepts the result
- op_count  output  16  number of completed response handshakes; wraps at 2^16

## Operation
- Arithmetic: the selected A, B and sub are muxed into cla19 with Cin = sub. Result = A + B, or A + ~B + 1 when sub = 1. The result is truncated to 19 bits. There is no carry or overflow output.
- can_accept = !rsp_valid || rsp_ready.
- Round-robin arbitration:
  - A priority pointer ptr (2 bits) gives first priority to requester ptr, then ptr+1, ptr+2, ptr+3 (mod 4).
  - grant = the first requester in that order with req_valid high. No requester is valid → no grant.
  - req_ready = grant one-hot AND can_accept AND !rst. It is combinational from req_valid, ptr, rsp_valid and rsp_ready.
- On a request handshake from requester i:
  - rsp_data ← adder result, rsp_id ← i, rsp_valid ← 1, ptr ← (i+1) mod 4.
- On a response handshake (rsp_valid && rsp_ready) with no new request handshake in the same cycle: rsp_valid ← 0, and rsp_data/rsp_id hold their values.
- When both handshakes occur in the same cycle, the new result replaces the old one and rsp_valid stays 1. This sustains one operation per cycle.
- op_count increments by 1 on every response handshake and wraps from 0xFFFF to 0x0000.
- ptr does not change in cycles without a request handshake.
- Requester obligations: hold req_valid, req_a, req_b and req_sub stable until accepted. The arbiter never drops an asserted request.
- Fairness: a continuously valid requester is granted within 4 request handshakes.

## Timing
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, op_count=0, ptr=0. req_ready is 0 while rst is high.
- Reset asserted mid-operation discards any pending result without a handshake. op_count is cleared.
- Latency: a request accepted at edge k has rsp_valid=1 with its result during cycle k+1.
- Throughput is 1 operation per cycle while rsp_ready is held high.
- Under backpressure (rsp_valid=1, rsp_ready=0):
  - req_ready is all zero.
  - rsp_data, rsp_id and rsp_valid hold.
  - ptr holds.
- Changes to req_valid have no effect until the next edge. The only combinational path is req_* / rsp_ready → req_ready.

## Test plan
- Reset, then a single request: requester 2 sends A=0x00005, B=0x00003, sub=1.
  - Expect req_ready=4'b0100 in the same cycle.
  - Next cycle: rsp_valid=1, rsp_data=0x00002, rsp_id=2.
  - After a rsp_ready handshake: op_count=1.
- Wrap-around arithmetic:
  - A=0x00000, B=0x00001, sub=1 → 0x7FFFF.
  - A=0x7FFFF, B=0x00001, sub=0 → 0x00000.
  - A=0x40000, B=0x40000, sub=0 → 0x00000.
- Round-robin: all four requesters valid continuously, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1 on consecutive cycles, one result per cycle.
- Backpressure: hold rsp_ready=0 for 3 cycles after a result from requester 1 → rsp_data and rsp_id stay stable, req_ready=0, ptr unchanged. On release, requester 2 is granted before requester 0.
- Simultaneous handshakes: rsp_ready=1 while a new request is accepted → rsp_valid stays 1, the new result appears the next cycle, and op_count increments once.
- Reset mid-stream: assert rst while rsp_valid=1 → next cycle rsp_valid=0, op_count=0, ptr=0. The first grant after reset goes to the lowest-numbered valid requester. Also drive 65,536 response handshakes → op_count wraps to 0.
